dmem_rr_arbiter: RTL
====================

// Module: dmem_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single-port data memory (data_mem) among NUM_CORES cores.
//  Each core raises a read or write request; the arbiter serialises them and issues one memory op at a time.
//  It returns read data plus a one-cycle acknowledge to the winning core.
//  Sits between the core array and data_mem, in place of a fixed-priority dmem mux.
// PARAMETERS
//  WIDTH      8  data/address width (bits)
//  NUM_CORES  4  number of requesters; >=2
//  RD_LAT     1  data_mem read latency in cycles from rEn edge to valid mem_rdata; >=1
// PORTS
//  Clk        in   1                  clock, all logic rising-edge
//  rst_n      in   1                  asynchronous active-low reset
//  req_rd     in   NUM_CORES          per-core read request, held until ack
//  req_wr     in   NUM_CORES          per-core write request, held until ack
//  core_done  in   NUM_CORES          core halted (coreS); its requests are masked
//  addr_in    in   NUM_CORES*WIDTH    packed addresses, core i at [i*WIDTH +: WIDTH]
//  wdata_in   in   NUM_CORES*WIDTH    packed write data, same packing
//  mem_rdata  in   WIDTH              data_mem read data
//  mem_rEn    out  1                  data_mem read enable
//  mem_wEn    out  1                  data_mem write enable
//  mem_addr   out  WIDTH              data_mem address
//  mem_wdata  out  WIDTH              data_mem write data
//  rdata_out  out  WIDTH              read data, broadcast to all cores; valid when ack high
//  ack        out  NUM_CORES          one-hot one-cycle completion pulse
//  grant_id   out  $clog2(NUM_CORES)  index of current/last granted core
//  busy       out  1                  high in any state except IDLE
//  err        out  1                  sticky: rd and wr asserted together by one core
// BEHAVIOUR
//  - All outputs are registered. On reset: state IDLE, ptr 0, every output 0, latched op discarded.
//    Because reset is asynchronous, an in-flight mem_wEn drops immediately.
//  - eligible = (req_rd | req_wr) & ~core_done.
//  - IDLE: if eligible != 0, pick the first set bit scanning ptr, ptr+1, ... (mod NUM_CORES).
//    Latch id, addr, wdata and op (write wins if both set; also sets err). Go to ISSUE. Otherwise stay.
//  - ISSUE (1 cycle): drive mem_addr/mem_wdata from latches; mem_wEn=1 for write, mem_rEn=1 for read.
//    Next: write -> ACK; read -> WAIT.
//  - WAIT (RD_LAT cycles, down-counter): on the last cycle capture mem_rdata into rdata_out. Then -> ACK.
//  - ACK (1 cycle): ack[id]=1; rdata_out holds captured data (unchanged on write); ptr <= (id+1) mod NUM_CORES.
//    Then -> IDLE.
//  - Requester rule: deassert the request on the clock edge where its ack is sampled high.
//    A request still high in the following IDLE cycle is treated as a new request.
//  - Latency, request sampled in IDLE to ack high: write 2 cycles; read 2+RD_LAT cycles.
//  - mem_rEn/mem_wEn are never high outside ISSUE and never high together.
//  - Requests that change or drop mid-transaction are ignored; latched values are used.
//  - core_done rising mid-transaction still completes that transaction.
//  - ptr wraps NUM_CORES-1 -> 0. The picker must be starvation-free: each eligible core is served
//    within NUM_CORES transactions.
// STRUCTURE
//  - Package dmem_arb_pkg: state enum {IDLE, ISSUE, WAIT, ACK}, op enum {OP_RD, OP_WR},
//    and an ID_W = $clog2(NUM_CORES) helper.
//  - Sub-module rr_pick: combinational rotating-priority picker.
//    Inputs: eligible vector, ptr. Outputs: found, winner index.
//  - Top holds the FSM, latches, RD_LAT counter and output registers.
// TESTING
//  1. Reset: hold rst_n=0 with random requests -> all outputs 0, busy=0.
//     Assert rst_n=0 mid-ISSUE of a write -> mem_wEn falls with no clock edge.
//  2. Single write, core2 addr=0x40 data=0xA5 -> one cycle of mem_wEn, addr 0x40, wdata 0xA5.
//     ack=4'b0100 two cycles after the request is sampled.
//  3. Single read, core1 addr=0x10, memory holds 0x3C, RD_LAT=1 -> mem_rEn one cycle,
//     then ack=4'b0010 with rdata_out=0x3C, three cycles after the request is sampled.
//  4. All four cores request continuously from reset -> grant order 0,1,2,3,0,...
//     Never two acks in one cycle; no core waits more than 4 transactions.
//  5. core_done=4'b1010 with all requesting -> only cores 0 and 2 are granted, alternating.
//  6. Core3 asserts rd and wr together -> write performed, err=1 and stays 1 until reset.

Source files
------------

// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared types for the data-memory round-robin arbiter: FSM states, op kinds
// and the index-width helper used to size core ids and counters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // Index width for n items; never below one bit so single-value fields stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Core-array / data_mem bus seen by the arbiter: per-core requests in, one
// memory port out, plus broadcast read data and per-core acknowledge.
interface dmem_rr_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_CORES = 4
);
  import dmem_arb_pkg::*;

  localparam int ID_W = id_w(NUM_CORES);

  logic [NUM_CORES-1:0]       req_rd;
  logic [NUM_CORES-1:0]       req_wr;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES*WIDTH-1:0] addr_in;
  logic [NUM_CORES*WIDTH-1:0] wdata_in;
  logic [WIDTH-1:0]           mem_rdata;
  logic                       mem_rEn;
  logic                       mem_wEn;
  logic [WIDTH-1:0]           mem_addr;
  logic [WIDTH-1:0]           mem_wdata;
  logic [WIDTH-1:0]           rdata_out;
  logic [NUM_CORES-1:0]       ack;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;
  logic                       err;

  modport master (
    input  req_rd, req_wr, core_done, addr_in, wdata_in, mem_rdata,
    output mem_rEn, mem_wEn, mem_addr, mem_wdata, rdata_out, ack, grant_id, busy, err
  );

  modport slave (
    output req_rd, req_wr, core_done, addr_in, wdata_in, mem_rdata,
    input  mem_rEn, mem_wEn, mem_addr, mem_wdata, rdata_out, ack, grant_id, busy, err
  );

endinterface

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible core scanning ptr, ptr+1, ...
// modulo NUM_CORES. Purely combinational.
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 2
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [ID_W-1:0]      ptr,
  output logic                 found,
  output logic [ID_W-1:0]      winner
);

  logic [ID_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_CORES);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto the
// single-port data_mem; one op at a time, one-cycle ack to the winner.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CORES = 4,
  parameter int RD_LAT    = 1
) (
  input logic               clk,
  input logic               rst_n,
  dmem_rr_arbiter_if.master bus
);

  localparam int ID_W  = id_w(NUM_CORES);
  localparam int CNT_W = id_w(RD_LAT);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ID_W-1:0]   ptr, lat_id;
  op_t               lat_op;
  logic [WIDTH-1:0]  lat_addr, lat_wdata;

  logic [NUM_CORES-1:0] eligible;
  logic                 found, pick;
  logic [ID_W-1:0]      winner;
  logic [WIDTH-1:0]     addr_sel, wdata_sel;

  logic              ren_q, ren_d, wen_q, wen_d, busy_q, busy_d, err_q, err_d;
  logic [WIDTH-1:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [ID_W-1:0]   grant_q, grant_d;

  assign eligible  = (bus.req_rd | bus.req_wr) & ~bus.core_done;
  assign pick      = (state == IDLE) && found;
  assign addr_sel  = bus.addr_in[winner*WIDTH +: WIDTH];
  assign wdata_sel = bus.wdata_in[winner*WIDTH +: WIDTH];

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (ID_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (found),
    .winner   (winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:  if (found) state_d = ISSUE;
      ISSUE: begin
        if (lat_op == OP_WR) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = ACK;
        else           cnt_d   = cnt - 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches; requests may change after the pick, these may not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      lat_id    <= '0;
      lat_op    <= OP_RD;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      if (pick) begin
        lat_id    <= winner;
        lat_op    <= bus.req_wr[winner] ? OP_WR : OP_RD;
        lat_addr  <= addr_sel;
        lat_wdata <= wdata_sel;
      end
      if (state == ACK) ptr <= (lat_id == LAST_ID) ? '0 : lat_id + 1'b1;
    end
  end

  // Outputs are registered, so their next values follow the next state.
  always_comb begin
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    grant_d = grant_q;
    busy_d  = (state_d != IDLE);
    err_d   = err_q;
    if (pick) begin
      wen_d   = bus.req_wr[winner];
      ren_d   = ~bus.req_wr[winner];
      addr_d  = addr_sel;
      wdata_d = wdata_sel;
      grant_d = winner;
      err_d   = err_q | (bus.req_rd[winner] & bus.req_wr[winner]);
    end
    if ((state == WAIT) && (cnt == '0)) rdata_d = bus.mem_rdata;
    if (state_d == ACK) ack_d[lat_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_rEn   = ren_q;
  assign bus.mem_wEn   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata_out = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule
